apb_read_master: RTL and testbench



---
 rtl/apb_master_pkg.sv | 23 ++
 rtl/apb_wait_timer.sv | 35 +++
 rtl/apb_read_master.sv | 129 ++++++++++++
 tb/tb_apb_read_master.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// apb_master_pkg : shared types/constants for the APB read master (rev 1.0)
// ------------------------------------------------------------------
package apb_master_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_t;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;
   localparam int unsigned WAIT_CNT_W             = 8;
   localparam int unsigned ERR_CNT_W              = 8;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
      return (value == '1) ? value : value + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// apb_wait_timer : ACCESS wait-state counter with terminal-count flag (rev 1.0)
// ------------------------------------------------------------------
module apb_wait_timer
   import apb_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic pclk,
   input  logic preset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [WAIT_CNT_W-1:0] TERMINAL = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [WAIT_CNT_W-1:0] count;

   // Holds at the terminal value so a stalled FSM can never wrap the count.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == TERMINAL);

endmodule
`default_nettype wire

// File: rtl/apb_read_master.sv
`default_nettype none
// ------------------------------------------------------------------
// apb_read_master : single-outstanding APB read master with timeout (rev 1.0)
// ------------------------------------------------------------------
module apb_read_master
   import apb_master_pkg::*;
#(
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                 pclk,
   input  logic                 preset_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [ADDR_W-1:0]    cmd_addr,
   output logic                 psel,
   output logic                 penable,
   output logic                 pwrite,
   output logic [ADDR_W-1:0]    paddr,
   input  logic [DATA_W-1:0]    prdata,
   input  logic                 pready,
   input  logic                 pslverr,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATA_W-1:0]    rsp_data,
   output logic                 rsp_err,
   output logic                 rsp_timeout,
   output logic [ERR_CNT_W-1:0] err_count
);

   apb_state_t state;
   apb_state_t state_nxt;
   logic       timer_clear;
   logic       timer_enable;
   logic       timer_expired;

   apb_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .pclk     (pclk),
      .preset_n (preset_n),
      .clear    (timer_clear),
      .enable   (timer_enable),
      .expired  (timer_expired)
   );

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid)               state_nxt = SETUP;
         SETUP:                                state_nxt = ACCESS;
         ACCESS:  if (pready || timer_expired) state_nxt = RESP;
         RESP:    if (rsp_ready)               state_nxt = IDLE;
         default:                              state_nxt = IDLE;
      endcase
   end

   // Bus strobes decode straight from the async-reset state, so a reset
   // drops psel/penable/rsp_valid without waiting for a clock edge.
   always_comb begin
      cmd_ready    = 1'b0;
      psel         = 1'b0;
      penable      = 1'b0;
      rsp_valid    = 1'b0;
      timer_clear  = 1'b0;
      timer_enable = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = preset_n;
         end
         SETUP: begin
            psel        = 1'b1;
            timer_clear = 1'b1;
         end
         ACCESS: begin
            psel         = 1'b1;
            penable      = 1'b1;
            timer_enable = !pready;
         end
         RESP: begin
            rsp_valid = 1'b1;
         end
         default: begin
            cmd_ready = 1'b0;
         end
      endcase
   end

   assign pwrite = 1'b0;

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         paddr       <= '0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         err_count   <= '0;
      end else begin
         if (state == IDLE && cmd_valid) begin
            paddr <= cmd_addr;
         end
         if (state == ACCESS) begin
            if (pready) begin
               rsp_data    <= prdata;
               rsp_err     <= pslverr;
               rsp_timeout <= 1'b0;
            end else if (timer_expired) begin
               rsp_data    <= '0;
               rsp_err     <= 1'b1;
               rsp_timeout <= 1'b1;
            end
         end
         if (state == RESP && rsp_ready && rsp_err) begin
            err_count <= sat_inc(err_count);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_read_master.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_apb_read_master : transaction-level model check of apb_read_master (rev 1.0)
// ------------------------------------------------------------------
module tb_apb_read_master;

   localparam int T = 16;

   logic       pclk;
   logic       preset_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_addr;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       rsp_timeout;
   logic [7:0] err_count;

   apb_read_master #(
      .ADDR_W         (8),
      .DATA_W         (8),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .pclk        (pclk),
      .preset_n    (preset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .prdata      (prdata),
      .pready      (pready),
      .pslverr     (pslverr),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .err_count   (err_count)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Transaction model: k counts cycles since accept (0 = setup,
   // 1..acc_len = access, beyond = response waiting for handshake).
   bit         m_busy;
   int         m_k;
   int         m_len;
   int         m_waits;
   logic [7:0] m_addr;
   logic [7:0] m_data;
   logic       m_err;
   logic       m_to;
   int         m_errcnt;

   int         next_waits;
   logic [7:0] next_data;
   logic       next_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy   = 1'b0;
      m_k      = 0;
      m_errcnt = 0;
   endtask

   task automatic model_edge();
      if (!preset_n) begin
         model_reset();
      end else if (!m_busy) begin
         if (cmd_valid) begin
            m_busy  = 1'b1;
            m_k     = 0;
            m_addr  = cmd_addr;
            m_waits = next_waits;
            if (next_waits < T) begin
               m_len  = next_waits + 1;
               m_data = next_data;
               m_err  = next_err;
               m_to   = 1'b0;
            end else begin
               m_len  = T;
               m_data = 8'h00;
               m_err  = 1'b1;
               m_to   = 1'b1;
            end
         end
      end else if (m_k > m_len) begin
         if (rsp_ready) begin
            m_busy = 1'b0;
            if (m_err && m_errcnt < 255) m_errcnt++;
         end
      end else begin
         m_k++;
      end
   endtask

   task automatic compare_cycle();
      bit in_bus;
      bit in_rsp;
      in_bus = m_busy && (m_k <= m_len);
      in_rsp = m_busy && (m_k > m_len);
      chk("cmd_ready", cmd_ready, preset_n && !m_busy);
      chk("psel", psel, in_bus);
      chk("penable", penable, in_bus && m_k >= 1);
      chk("pwrite", pwrite, 0);
      chk("rsp_valid", rsp_valid, in_rsp);
      chk("err_count", err_count, m_errcnt);
      if (in_bus) chk("paddr", paddr, m_addr);
      if (in_rsp) begin
         chk("rsp_data", rsp_data, m_data);
         chk("rsp_err", rsp_err, m_err);
         chk("rsp_timeout", rsp_timeout, m_to);
      end
      if (!preset_n) begin
         chk("rst_paddr", paddr, 0);
         chk("rst_rsp_data", rsp_data, 0);
         chk("rst_rsp_err", rsp_err, 0);
         chk("rst_rsp_timeout", rsp_timeout, 0);
      end
   endtask

   // Slave answers on access cycle waits+1; outside that cycle pready,
   // prdata and pslverr carry noise the master must ignore.
   task automatic drive_slave();
      bit in_access;
      in_access = m_busy && m_k >= 1 && m_k <= m_len;
      if (in_access && m_k == m_waits + 1) begin
         pready  = 1'b1;
         prdata  = m_data;
         pslverr = m_err;
      end else begin
         pready  = in_access ? 1'b0 : 1'($urandom_range(0, 1));
         prdata  = 8'($urandom);
         pslverr = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic step();
      @(posedge pclk);
      cyc++;
      model_edge();
      @(negedge pclk);
      compare_cycle();
      drive_slave();
   endtask

   task automatic do_txn(input logic [7:0] addr, input int w, input logic [7:0] d,
                         input logic e, input bit keep, output int lat, output int acc);
      int n;
      int c0;
      bit seen;
      next_waits = w;
      next_data  = d;
      next_err   = e;
      cmd_valid  = 1'b1;
      cmd_addr   = addr;
      rsp_ready  = 1'b0;
      n  = 0;
      c0 = cyc;
      do begin
         c0 = cyc;
         step();
         n++;
      end while (!m_busy && n < 8);
      if (!m_busy) chk("accept_bound", 0, 1);
      if (keep) cmd_addr = ~addr;
      else      cmd_valid = 1'b0;
      acc  = 0;
      lat  = -1;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 300) begin
         if (psel && penable) acc++;
         if (rsp_valid) begin
            lat  = cyc - c0;
            seen = 1'b1;
         end else begin
            step();
            n++;
         end
      end
      if (!seen) chk("rsp_valid_bound", 0, 1);
   endtask

   task automatic finish_rsp(input int hold);
      for (int i = 0; i < hold; i++) step();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic drain();
      int n;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      n = 0;
      while (m_busy && n < 60) begin
         step();
         n++;
      end
      if (m_busy) chk("drain_bound", 0, 1);
      rsp_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int acc;
      preset_n   = 1'b0;
      cmd_valid  = 1'b0;
      cmd_addr   = 8'h00;
      rsp_ready  = 1'b0;
      pready     = 1'b0;
      prdata     = 8'h00;
      pslverr    = 1'b0;
      next_waits = 0;
      next_data  = 8'h00;
      next_err   = 1'b0;
      model_reset();

      step();
      step();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_psel", psel, 0);
      chk("rst_err_count", err_count, 0);
      preset_n = 1'b1;
      step();

      // zero-wait read
      do_txn(8'h03, 0, 8'h42, 1'b0, 1'b0, lat, acc);
      chk("zw_latency", lat, 3);
      chk("zw_access_cycles", acc, 1);
      chk("zw_rsp_data", rsp_data, 8'h42);
      chk("zw_rsp_err", rsp_err, 0);
      finish_rsp(0);

      // five wait states
      do_txn(8'h5C, 5, 8'hA5, 1'b0, 1'b0, lat, acc);
      chk("ws_access_cycles", acc, 6);
      chk("ws_rsp_data", rsp_data, 8'hA5);
      finish_rsp(1);

      // slave error
      chk("se_err_count_before", err_count, 0);
      do_txn(8'h09, 0, 8'h77, 1'b1, 1'b0, lat, acc);
      chk("se_rsp_err", rsp_err, 1);
      chk("se_rsp_timeout", rsp_timeout, 0);
      finish_rsp(0);
      chk("se_err_count_after", err_count, 1);

      // timeout with pready stuck low
      do_txn(8'h21, 100, 8'h99, 1'b0, 1'b0, lat, acc);
      chk("to_access_cycles", acc, 16);
      chk("to_rsp_timeout", rsp_timeout, 1);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_data", rsp_data, 8'h00);
      finish_rsp(0);
      chk("to_err_count", err_count, 2);

      // pready on the last allowed access cycle still wins
      do_txn(8'h22, T - 1, 8'h3C, 1'b0, 1'b0, lat, acc);
      chk("edge_access_cycles", acc, 16);
      chk("edge_rsp_timeout", rsp_timeout, 0);
      chk("edge_rsp_data", rsp_data, 8'h3C);
      finish_rsp(0);

      // backpressure with a second command waiting
      do_txn(8'h40, 2, 8'h11, 1'b0, 1'b1, lat, acc);
      finish_rsp(4);
      chk("bp_cmd_ready_idle", cmd_ready, 1);
      chk("bp_rsp_valid_idle", rsp_valid, 0);
      step();
      chk("bp_next_psel", psel, 1);
      chk("bp_next_penable", penable, 0);
      chk("bp_next_paddr", paddr, 8'hBF);
      drain();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         cmd_valid  = ($urandom_range(0, 2) != 0);
         cmd_addr   = 8'($urandom);
         rsp_ready  = ($urandom_range(0, 2) != 0);
         next_waits = ($urandom_range(0, 9) == 0) ? T + int'($urandom_range(0, 3))
                                                  : int'($urandom_range(0, 4));
         next_data  = 8'($urandom);
         next_err   = ($urandom_range(0, 3) == 0);
         step();
      end
      drain();

      // error counter saturation
      for (int i = 0; i < 260; i++) begin
         do_txn(8'($urandom), 0, 8'($urandom), 1'b1, 1'b0, lat, acc);
         finish_rsp(0);
      end
      chk("sat_err_count", err_count, 255);

      // asynchronous reset in the middle of ACCESS
      next_waits = 10;
      next_err   = 1'b0;
      cmd_valid  = 1'b1;
      cmd_addr   = 8'h55;
      step();
      cmd_valid = 1'b0;
      step();
      step();
      chk("mid_penable_before", penable, 1);
      #2;
      preset_n = 1'b0;
      #1;
      chk("mid_psel", psel, 0);
      chk("mid_penable", penable, 0);
      chk("mid_rsp_valid", rsp_valid, 0);
      chk("mid_err_count", err_count, 0);
      chk("mid_cmd_ready", cmd_ready, 0);
      step();
      step();
      preset_n = 1'b1;

      // first command after release
      do_txn(8'h6E, 0, 8'hC3, 1'b0, 1'b0, lat, acc);
      chk("post_rst_latency", lat, 3);
      chk("post_rst_rsp_data", rsp_data, 8'hC3);
      finish_rsp(0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
